// File: rtl/dft_sched.sv
// Operation scheduler between host, DUT and DFT controller: forwards host ops to the DUT,
// inserts scan-dump snapshots periodically or on request, and re-times dump words for the host.
module dft_sched #(
  parameter int unsigned SNAP_INTERVAL = 16,
  parameter int unsigned DUMP_WORDS    = 1,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_val_op,
  output logic        h_op_ack,
  output logic        h_op_commit,
  input  logic        h_commit_ack,
  input  logic        h_snap_req,
  output logic        dut_val_op,
  input  logic        dut_op_ack,
  input  logic        dut_op_commit,
  output logic        dut_commit_ack,
  output logic        dft_val_op,
  input  logic        dft_op_ack,
  input  logic        dft_op_commit,
  output logic        dft_commit_ack,
  input  logic        dft_out_strobe,
  input  logic [31:0] dft_out,
  output logic [31:0] snap_data,
  output logic        snap_valid,
  output logic        snap_done,
  output logic        snap_busy,
  output logic        snap_err,
  output logic [31:0] op_count
);

  localparam logic [31:0] INTERVAL_LIM = 32'(SNAP_INTERVAL);
  localparam logic [31:0] WORDS_EXP    = 32'(DUMP_WORDS);
  localparam logic [31:0] WD_LAST      = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUT_REQ,
    S_DUT_RUN,
    S_DUT_CMT,
    S_SNAP_REQ,
    S_SNAP_RUN,
    S_SNAP_CMT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] opCount_q, opCount_d;
  logic [31:0] intervalCnt_q, intervalCnt_d;
  logic [31:0] wordCnt_q, wordCnt_d;
  logic [31:0] wdCnt_q, wdCnt_d;
  logic        snapPend_q, snapPend_d;
  logic        snapErr_q, snapErr_d;
  logic [31:0] snapData_q, snapData_d;
  logic        snapValid_q, snapValid_d;
  logic        snapDone_q, snapDone_d;
  logic        snapBusy_q, snapBusy_d;
  logic        hOpAck_q, hOpAck_d;
  logic        hOpCommit_q, hOpCommit_d;
  logic        dutValOp_q, dutValOp_d;
  logic        dutCommitAck_q, dutCommitAck_d;
  logic        dftValOp_q, dftValOp_d;
  logic        dftCommitAck_q, dftCommitAck_d;

  logic        snapEnter;
  logic        wdExpire;
  logic        dutCommit;
  logic        wordCapture;
  logic        inSnapWindow;
  logic        autoHit;

  always_comb begin
    state_d   = state_q;
    snapEnter = 1'b0;
    wdExpire  = 1'b0;
    dutCommit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (snapPend_q) begin
          state_d   = S_SNAP_REQ;
          snapEnter = 1'b1;
        end else if (h_val_op) begin
          state_d = S_DUT_REQ;
        end
      end
      S_DUT_REQ: begin
        if (dut_op_ack) state_d = S_DUT_RUN;
      end
      S_DUT_RUN: begin
        if (dut_op_commit) state_d = S_DUT_CMT;
      end
      S_DUT_CMT: begin
        if (h_commit_ack) begin
          state_d   = S_IDLE;
          dutCommit = 1'b1;
        end
      end
      // The watchdog abort takes precedence over a handshake arriving in its last cycle.
      S_SNAP_REQ: begin
        if (wdCnt_q == WD_LAST) begin
          state_d  = S_IDLE;
          wdExpire = 1'b1;
        end else if (dft_op_ack) begin
          state_d = S_SNAP_RUN;
        end
      end
      S_SNAP_RUN: begin
        if (wdCnt_q == WD_LAST) begin
          state_d  = S_IDLE;
          wdExpire = 1'b1;
        end else if (dft_op_commit) begin
          state_d = S_SNAP_CMT;
        end
      end
      S_SNAP_CMT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    inSnapWindow = (state_q == S_SNAP_REQ) || (state_q == S_SNAP_RUN);
    wordCapture  = (state_q == S_SNAP_RUN) && dft_out_strobe;
    autoHit      = dutCommit && (INTERVAL_LIM != 32'd0) &&
                   (intervalCnt_q + 32'd1 == INTERVAL_LIM) && !snapErr_q;

    opCount_d = opCount_q;
    if (dutCommit) opCount_d = opCount_q + 32'd1;

    intervalCnt_d = intervalCnt_q;
    if (snapEnter) intervalCnt_d = 32'd0;
    else if (dutCommit) intervalCnt_d = intervalCnt_q + 32'd1;

    wordCnt_d = wordCnt_q;
    if (snapEnter) wordCnt_d = 32'd0;
    else if (wordCapture) wordCnt_d = wordCnt_q + 32'd1;

    wdCnt_d = wdCnt_q;
    if (snapEnter) wdCnt_d = 32'd0;
    else if (inSnapWindow) wdCnt_d = wdCnt_q + 32'd1;

    // A request landing on the entry cycle is kept and served by a later snapshot.
    snapPend_d = (snapPend_q && !snapEnter) || h_snap_req || autoHit;
    snapErr_d  = snapErr_q || wdExpire ||
                 ((state_q == S_SNAP_CMT) && (wordCnt_q != WORDS_EXP));

    snapData_d     = wordCapture ? dft_out : snapData_q;
    snapValid_d    = wordCapture;
    snapDone_d     = (state_d == S_SNAP_CMT) || wdExpire;
    snapBusy_d     = (state_d == S_SNAP_REQ) || (state_d == S_SNAP_RUN) ||
                     (state_d == S_SNAP_CMT);
    hOpAck_d       = (state_q == S_DUT_REQ) && dut_op_ack;
    hOpCommit_d    = (state_d == S_DUT_CMT);
    dutValOp_d     = (state_d == S_DUT_REQ);
    dutCommitAck_d = dutCommit;
    dftValOp_d     = (state_d == S_SNAP_REQ);
    dftCommitAck_d = (state_d == S_SNAP_CMT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      opCount_q      <= 32'd0;
      intervalCnt_q  <= 32'd0;
      wordCnt_q      <= 32'd0;
      wdCnt_q        <= 32'd0;
      snapPend_q     <= 1'b0;
      snapErr_q      <= 1'b0;
      snapData_q     <= 32'd0;
      snapValid_q    <= 1'b0;
      snapDone_q     <= 1'b0;
      snapBusy_q     <= 1'b0;
      hOpAck_q       <= 1'b0;
      hOpCommit_q    <= 1'b0;
      dutValOp_q     <= 1'b0;
      dutCommitAck_q <= 1'b0;
      dftValOp_q     <= 1'b0;
      dftCommitAck_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      opCount_q      <= opCount_d;
      intervalCnt_q  <= intervalCnt_d;
      wordCnt_q      <= wordCnt_d;
      wdCnt_q        <= wdCnt_d;
      snapPend_q     <= snapPend_d;
      snapErr_q      <= snapErr_d;
      snapData_q     <= snapData_d;
      snapValid_q    <= snapValid_d;
      snapDone_q     <= snapDone_d;
      snapBusy_q     <= snapBusy_d;
      hOpAck_q       <= hOpAck_d;
      hOpCommit_q    <= hOpCommit_d;
      dutValOp_q     <= dutValOp_d;
      dutCommitAck_q <= dutCommitAck_d;
      dftValOp_q     <= dftValOp_d;
      dftCommitAck_q <= dftCommitAck_d;
    end
  end

  assign h_op_ack       = hOpAck_q;
  assign h_op_commit    = hOpCommit_q;
  assign dut_val_op     = dutValOp_q;
  assign dut_commit_ack = dutCommitAck_q;
  assign dft_val_op     = dftValOp_q;
  assign dft_commit_ack = dftCommitAck_q;
  assign snap_data      = snapData_q;
  assign snap_valid     = snapValid_q;
  assign snap_done      = snapDone_q;
  assign snap_busy      = snapBusy_q;
  assign snap_err       = snapErr_q;
  assign op_count       = opCount_q;

endmodule

// File: tb/tb_dft_sched.sv
// Scoreboard bench for dft_sched: host driver plus DUT/DFT responders feed expected events
// into queues; a negedge monitor pops and compares whenever the scheduler presents an output.
module tb_dft_sched;

  localparam int unsigned SNAP_INTERVAL = 2;
  localparam int unsigned DUMP_WORDS    = 3;
  localparam int unsigned TIMEOUT       = 16;
  localparam logic [7:0]  KD = 8'h44;
  localparam logic [7:0]  KS = 8'h53;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        h_val_op = 1'b0, h_op_ack, h_op_commit, h_commit_ack = 1'b0, h_snap_req = 1'b0;
  logic        dut_val_op, dut_op_ack = 1'b0, dut_op_commit = 1'b0, dut_commit_ack;
  logic        dft_val_op, dft_op_ack = 1'b0, dft_op_commit = 1'b0, dft_commit_ack;
  logic        dft_out_strobe = 1'b0;
  logic [31:0] dft_out = 32'd0;
  logic [31:0] snap_data, op_count;
  logic        snap_valid, snap_done, snap_busy, snap_err;

  int unsigned compared = 0, mismatched = 0;

  logic [7:0]  kindQ[$];
  logic [31:0] snapQ[$];
  logic [31:0] cntQ[$];
  logic        errQ[$];

  // Transaction-level model state, owned by the main sequence.
  int unsigned modelCount = 0, modelInterval = 0;
  bit          modelOwed = 1'b0;
  int unsigned errBase = 0;
  // Owned by the DFT responder: number of snapshots that ended badly.
  int unsigned errSnaps = 0;

  int          dutAckDelay = 2;
  int          dftWords = 3;
  bit          dftNoAck = 1'b0;
  bit          fixedWords = 1'b0;
  int unsigned strayReq = 0;

  always #5 clk = ~clk;

  dft_sched #(
    .SNAP_INTERVAL(SNAP_INTERVAL),
    .DUMP_WORDS(DUMP_WORDS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .h_val_op(h_val_op),
    .h_op_ack(h_op_ack),
    .h_op_commit(h_op_commit),
    .h_commit_ack(h_commit_ack),
    .h_snap_req(h_snap_req),
    .dut_val_op(dut_val_op),
    .dut_op_ack(dut_op_ack),
    .dut_op_commit(dut_op_commit),
    .dut_commit_ack(dut_commit_ack),
    .dft_val_op(dft_val_op),
    .dft_op_ack(dft_op_ack),
    .dft_op_commit(dft_op_commit),
    .dft_commit_ack(dft_commit_ack),
    .dft_out_strobe(dft_out_strobe),
    .dft_out(dft_out),
    .snap_data(snap_data),
    .snap_valid(snap_valid),
    .snap_done(snap_done),
    .snap_busy(snap_busy),
    .snap_err(snap_err),
    .op_count(op_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failExtra(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: DUT produced an event with nothing expected", name);
  endtask

  // Model of the scheduler's bookkeeping at one committed host op.
  task automatic modelCommit();
    modelCount++;
    modelInterval++;
    cntQ.push_back(32'(modelCount));
    if (modelInterval == SNAP_INTERVAL && (errSnaps == errBase) && !modelOwed) begin
      kindQ.push_back(KS);
      modelOwed = 1'b1;
    end
    if (modelOwed) begin
      modelInterval = 0;
      modelOwed = 1'b0;
    end
  endtask

  // One full host operation; optionally checks request latency and pulses manual snapshots mid-op.
  task automatic applyStimulus(input int commitDelay, input bit checkLatency, input int snapPulses);
    int i;
    kindQ.push_back(KD);
    h_val_op = 1'b1;
    if (checkLatency) begin
      @(negedge clk);
      checkOutput("reqLatency", 32'(dut_val_op), 1);
    end
    i = 0;
    while (!h_op_ack && i < 300) begin
      @(negedge clk);
      i++;
    end
    h_val_op = 1'b0;
    checkOutput("opAckSeen", 32'(h_op_ack), 1);
    for (int k = 0; k < snapPulses; k++) begin
      h_snap_req = 1'b1;
      if (!modelOwed) begin
        kindQ.push_back(KS);
        modelOwed = 1'b1;
      end
      @(negedge clk);
      h_snap_req = 1'b0;
      checkOutput("noEarlySnap", 32'(dft_val_op), 0);
      @(negedge clk);
    end
    i = 0;
    while (!h_op_commit && i < 300) begin
      @(negedge clk);
      i++;
    end
    checkOutput("opCommitSeen", 32'(h_op_commit), 1);
    repeat (commitDelay) @(negedge clk);
    h_commit_ack = 1'b1;
    modelCommit();
    @(negedge clk);
    h_commit_ack = 1'b0;
    if (snapPulses > 0) begin
      checkOutput("commitAckPulse", 32'(dut_commit_ack), 1);
      checkOutput("snapNotYet", 32'(dft_val_op), 0);
      @(negedge clk);
      checkOutput("snapAfterCommit", 32'(dft_val_op), 1);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelCount = 0;
    modelInterval = 0;
    modelOwed = 1'b0;
    errBase = errSnaps;
  endtask

  task automatic settleAndDrain(input string tag);
    repeat (60) @(negedge clk);
    checkOutput({tag, "_kindQ"}, 32'(kindQ.size()), 0);
    checkOutput({tag, "_snapQ"}, 32'(snapQ.size()), 0);
    checkOutput({tag, "_cntQ"}, 32'(cntQ.size()), 0);
    checkOutput({tag, "_errQ"}, 32'(errQ.size()), 0);
  endtask

  // DUT-side responder: acknowledges and later commits each forwarded op.
  initial begin : dutAgent
    forever begin
      @(negedge clk);
      if (dut_val_op && !reset) begin
        repeat ((dutAckDelay < 0) ? $urandom_range(0, 3) : dutAckDelay) @(negedge clk);
        dut_op_ack = 1'b1;
        @(negedge clk);
        dut_op_ack = 1'b0;
        checkOutput("hOpAckPulse", 32'(h_op_ack), 1);
        checkOutput("dutValDrop", 32'(dut_val_op), 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        dut_op_commit = 1'b1;
        @(negedge clk);
        dut_op_commit = 1'b0;
      end
    end
  end

  // DFT-side responder: acks a scan request and streams dump words, or withholds the ack.
  initial begin : dftAgent
    int unsigned strayDone = 0;
    bit coincide;
    int n;
    forever begin
      @(negedge clk);
      if (strayDone != strayReq && !dft_val_op) begin
        dft_out = 32'h5A5A5A5A;
        dft_out_strobe = 1'b1;
        @(negedge clk);
        dft_out_strobe = 1'b0;
        strayDone++;
      end else if (dft_val_op && !reset) begin
        if (dftNoAck) begin
          errSnaps++;
          errQ.push_back(1'b1);
          n = 1;
          while (dft_val_op && n < 200) begin
            @(negedge clk);
            if (dft_val_op) n++;
          end
          checkOutput("timeoutLen", 32'(n), TIMEOUT);
          checkOutput("abortSnapDone", 32'(snap_done), 1);
        end else begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          dft_op_ack = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            dft_out = $urandom;
            dft_out_strobe = 1'b1;
          end
          @(negedge clk);
          dft_op_ack = 1'b0;
          dft_out_strobe = 1'b0;
          coincide = fixedWords ? 1'b1 : 1'($urandom_range(0, 1));
          for (int w = 0; w < dftWords; w++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            dft_out = fixedWords ? (32'hA5A50001 + 32'(w)) : $urandom;
            dft_out_strobe = 1'b1;
            snapQ.push_back(dft_out);
            if (w == dftWords - 1 && coincide) dft_op_commit = 1'b1;
            @(negedge clk);
            dft_out_strobe = 1'b0;
            dft_op_commit = 1'b0;
          end
          if (!coincide) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            dft_op_commit = 1'b1;
            @(negedge clk);
            dft_op_commit = 1'b0;
          end
          if (dftWords != int'(DUMP_WORDS)) errSnaps++;
          errQ.push_back(errSnaps != errBase);
        end
      end
    end
  end

  // Monitor: compares every scheduler output event against the expected queues.
  initial begin : monitor
    logic dutPrev, dftPrev, donePrev;
    dutPrev = 1'b0;
    dftPrev = 1'b0;
    donePrev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        dutPrev = 1'b0;
        dftPrev = 1'b0;
        donePrev = 1'b0;
      end else begin
        if (dut_val_op && !dutPrev) begin
          if (kindQ.size() > 0) checkOutput("opOrderDut", 32'(KD), 32'(kindQ.pop_front()));
          else failExtra("opOrderDut");
        end
        if (dft_val_op && !dftPrev) begin
          if (kindQ.size() > 0) checkOutput("opOrderSnap", 32'(KS), 32'(kindQ.pop_front()));
          else failExtra("opOrderSnap");
        end
        if (snap_valid) begin
          if (snapQ.size() > 0) checkOutput("snapData", snap_data, snapQ.pop_front());
          else failExtra("snapValid");
        end
        if (dut_commit_ack) begin
          if (cntQ.size() > 0) checkOutput("opCount", op_count, cntQ.pop_front());
          else failExtra("dutCommitAck");
        end
        if (donePrev) begin
          if (errQ.size() > 0) checkOutput("snapErr", 32'(snap_err), 32'(errQ.pop_front()));
          else failExtra("snapDone");
        end
        dutPrev = dut_val_op;
        dftPrev = dft_val_op;
        donePrev = snap_done;
      end
    end
  end

  initial begin : mainSeq
    int i;
    doReset();
    repeat (10) @(negedge clk);
    checkOutput("rstHOpAck", 32'(h_op_ack), 0);
    checkOutput("rstHOpCommit", 32'(h_op_commit), 0);
    checkOutput("rstDutVal", 32'(dut_val_op), 0);
    checkOutput("rstDutCommitAck", 32'(dut_commit_ack), 0);
    checkOutput("rstDftVal", 32'(dft_val_op), 0);
    checkOutput("rstDftCommitAck", 32'(dft_commit_ack), 0);
    checkOutput("rstSnapData", snap_data, 0);
    checkOutput("rstSnapValid", 32'(snap_valid), 0);
    checkOutput("rstSnapDone", 32'(snap_done), 0);
    checkOutput("rstSnapBusy", 32'(snap_busy), 0);
    checkOutput("rstSnapErr", 32'(snap_err), 0);
    checkOutput("rstOpCount", op_count, 0);

    $display("[TB] periodic snapshot, fixed dump words");
    dutAckDelay = 2;
    fixedWords = 1'b1;
    applyStimulus(1, 1'b1, 0);
    applyStimulus(0, 1'b0, 0);
    checkOutput("countBeforeSnap", op_count, 2);
    applyStimulus(2, 1'b0, 0);
    checkOutput("countAfterSnap", op_count, 3);
    fixedWords = 1'b0;

    $display("[TB] randomized ops and snapshots");
    dutAckDelay = -1;
    for (int k = 0; k < 20; k++) applyStimulus($urandom_range(0, 2), 1'b0, 0);
    settleAndDrain("rand");
    checkOutput("randNoErr", 32'(snap_err), 0);
    checkOutput("randCount", op_count, 23);

    $display("[TB] short dump sets sticky error and stops auto snapshots");
    doReset();
    dftWords = 2;
    applyStimulus(0, 1'b0, 0);
    applyStimulus(0, 1'b0, 0);
    repeat (60) @(negedge clk);
    checkOutput("errSet", 32'(snap_err), 1);
    dftWords = 3;
    strayReq++;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 10; k++) applyStimulus($urandom_range(0, 2), 1'b0, 0);
    settleAndDrain("err");
    checkOutput("errSticky", 32'(snap_err), 1);
    checkOutput("errCount", op_count, 12);

    $display("[TB] coalesced manual requests");
    doReset();
    applyStimulus(1, 1'b0, 3);
    settleAndDrain("manual");
    checkOutput("manualNoErr", 32'(snap_err), 0);

    $display("[TB] watchdog abort");
    dftNoAck = 1'b1;
    h_snap_req = 1'b1;
    kindQ.push_back(KS);
    modelInterval = 0;
    @(negedge clk);
    h_snap_req = 1'b0;
    i = 0;
    while (!snap_done && i < 100) begin
      @(negedge clk);
      i++;
    end
    checkOutput("abortDoneSeen", 32'(snap_done), 1);
    repeat (5) @(negedge clk);
    dftNoAck = 1'b0;
    checkOutput("abortErr", 32'(snap_err), 1);
    checkOutput("abortIdle", 32'(snap_busy), 0);
    applyStimulus(0, 1'b0, 0);
    settleAndDrain("abort");
    checkOutput("finalCount", op_count, 32'(modelCount));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : globalTimeout
    #1000000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, compared=%0d", compared);
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/dft_sched.md
# dft_sched

Operation scheduler between the host and the DUT/DFT handshake ports of the scan-enabled test top. It forwards host DUT operations one at a time and counts committed operations. It inserts a scan-dump (DFT) operation every `SNAP_INTERVAL` commits or on host request, stalling DUT traffic while the scan chain is in use. Dump words from `dft_out` are re-timed into a host-facing snapshot stream, with word-count checking and a watchdog.

## Interface
- `SNAP_INTERVAL`, 16: committed DUT ops between automatic snapshots; 0 disables automatic snapshots.
- `DUMP_WORDS`, 1: expected `dft_out_strobe` pulses per snapshot; equals the DFT controller's `dump_nbr`.
- `TIMEOUT`, 1024: maximum cycles spent in SNAP_REQ + SNAP_RUN before abort.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `h_val_op` in 1: host DUT-operation request, held until `h_op_ack`.
- `h_op_ack` out 1: one-cycle acceptance pulse.
- `h_op_commit` out 1: DUT op complete, held until `h_commit_ack`.
- `h_commit_ack` in 1: host completion acknowledge.
- `h_snap_req` in 1: one-cycle manual snapshot request.
- `dut_val_op` out 1 / `dut_op_ack` in 1 / `dut_op_commit` in 1 / `dut_commit_ack` out 1: DUT handshake.
- `dft_val_op` out 1 / `dft_op_ack` in 1 / `dft_op_commit` in 1 / `dft_commit_ack` out 1: DFT controller handshake.
- `dft_out_strobe` in 1, `dft_out` in 32: dump word and its valid strobe.
- `snap_data` out 32, `snap_valid` out 1: registered dump word and one-cycle valid.
- `snap_done` out 1: one-cycle pulse at snapshot end.
- `snap_busy` out 1: high in SNAP_REQ, SNAP_RUN and SNAP_CMT.
- `snap_err` out 1: sticky error flag; cleared only by reset.
- `op_count` out 32: committed DUT ops; wraps modulo 2^32.

## Operation
- States: IDLE, DUT_REQ, DUT_RUN, DUT_CMT, SNAP_REQ, SNAP_RUN, SNAP_CMT. All outputs are registered (Moore or registered pulse).
- IDLE: if `snap_pend`, go to SNAP_REQ. Otherwise, if `h_val_op`, go to DUT_REQ. A pending snapshot has priority over a host op.
- DUT_REQ: `dut_val_op`=1. When `dut_op_ack` is sampled: go to DUT_RUN and pulse `h_op_ack` for one cycle.
- DUT_RUN: when `dut_op_commit` is sampled, go to DUT_CMT.
- DUT_CMT: `h_op_commit`=1. When `h_commit_ack` is sampled:
  - pulse `dut_commit_ack` for one cycle, increment `op_count` and the interval counter, then go to IDLE;
  - if `SNAP_INTERVAL`≠0 and the interval counter reaches `SNAP_INTERVAL`, set `snap_pend`.
- SNAP_REQ: `dft_val_op`=1. When `dft_op_ack` is sampled, go to SNAP_RUN. On entry, clear the interval counter, the word counter and `snap_pend`.
- SNAP_RUN: for each sampled `dft_out_strobe`, next cycle `snap_data`=`dft_out` and `snap_valid`=1, and the word counter increments. When `dft_op_commit` is sampled, go to SNAP_CMT.
- SNAP_CMT (one cycle): pulse `dft_commit_ack` and `snap_done`. If word count ≠ `DUMP_WORDS`, set `snap_err`. Go to IDLE.
- Watchdog: counts cycles in SNAP_REQ and SNAP_RUN. If it reaches `TIMEOUT`, set `snap_err`, drop `dft_val_op`, pulse `snap_done` and go to IDLE. After any `snap_err`, automatic triggering is disabled; manual requests are still honoured.
- `h_snap_req` in any state sets `snap_pend`. Multiple requests before service coalesce into one snapshot. Automatic and manual triggers in the same cycle produce one snapshot.

## Timing
- Reset: state IDLE; every output 0; `op_count`, interval counter, word counter, watchdog, `snap_pend` and `snap_err` all 0. Reset mid-operation aborts with no ack or commit pulses issued.
- `h_val_op` sampled in IDLE at edge t: `dut_val_op` is high from t+1. `dut_op_ack` sampled at edge k: `dut_val_op` drops and `h_op_ack`=1 for the cycle after k.
- `h_commit_ack` sampled at edge c: `dut_commit_ack`=1 and `op_count`+1 in the cycle after c; earliest next `dut_val_op` is c+2.
- `dft_out_strobe` and `dft_op_commit` in the same cycle: the word is captured and counted before the count check.
- Strobes outside SNAP_RUN are ignored and not counted.
- `op_count` wraps 0xFFFFFFFF→0 with no flag.

## Test plan
- Reset, then idle for 10 cycles → every output 0; `op_count`=0.
- `SNAP_INTERVAL`=2: three host ops, DUT acks each after 2 cycles → `op_count`=2, then `dft_val_op` before the third `dut_val_op`; third op completes after `snap_done`; `op_count`=3.
- `DUMP_WORDS`=3: strobes with 0xA5A50001, 0xA5A50002, 0xA5A50003, the last coincident with `dft_op_commit` → three `snap_valid` pulses carrying those values; `snap_err`=0.
- Only 2 strobes with `DUMP_WORDS`=3 → `snap_err`=1 after SNAP_CMT; no automatic snapshots after 10 further ops.
- `h_snap_req` pulsed 3 times during a DUT op → exactly one snapshot, started after that op's `dut_commit_ack`.
- `dft_op_ack` never returned, `TIMEOUT`=16 → `dft_val_op` drops at cycle 16, `snap_err`=1, `snap_done` pulses; the next host op proceeds.
